dmem_responder: RTL and testbench

Data-memory responder for the RISCV_core load/store path. It accepts one load or store request at a time over a valid/ready request channel and completes it after a fixed, parameterised number of wait states. It returns the result over a valid/ready response channel. It performs RISC-V byte/halfword/word lane alignment, sign or zero extension, alignment checking and range checking, and holds the data array internally.

---
 rtl/dmem_responder_pkg.sv | 20 ++
 rtl/dmem_responder_lane_align.sv | 71 +++++++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: load/store funct3 encodings and FSM states.
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } mem_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WS_MAX = 15;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Combinational byte-lane steering: store byte enables and shifted data, and
// load lane select with sign/zero extension. Also flags misalignment and bad funct3.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_sh_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [1:0]  sz;
    logic        uns;
    logic [4:0]  shamt;
    logic [31:0] raw_sh;
    logic        misalign;
    logic        bad_f3;

    assign sz  = funct3_i[1:0];
    assign uns = funct3_i[2];

    // Halfwords live in lanes {addr[1],0}/{addr[1],1}, so only addr[1] moves them.
    always_comb begin
        shamt = 5'd0;
        be_o  = 4'b0000;
        case (sz)
            2'd0: begin
                shamt = {addr_lo_i, 3'b000};
                be_o  = 4'b0001 << addr_lo_i;
            end
            2'd1: begin
                shamt = {addr_lo_i[1], 4'b0000};
                be_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                shamt = 5'd0;
                be_o  = 4'b1111;
            end
            default: begin
                shamt = 5'd0;
                be_o  = 4'b0000;
            end
        endcase
    end

    assign wdata_sh_o = wdata_i << shamt;
    assign raw_sh     = raw_i >> shamt;

    always_comb begin
        rdata_o = raw_i;
        case (sz)
            2'd0:    rdata_o = {{24{~uns & raw_sh[7]}}, raw_sh[7:0]};
            2'd1:    rdata_o = {{16{~uns & raw_sh[15]}}, raw_sh[15:0]};
            default: rdata_o = raw_i;
        endcase
    end

    assign misalign = ((sz == 2'd1) && addr_lo_i[0]) || ((sz == 2'd2) && (addr_lo_i != 2'b00));

    // Stores allow only 0..2; loads additionally allow the unsigned byte/half forms.
    assign bad_f3 = we_i ? (uns || (sz == 2'd3))
                         : ((sz == 2'd3) || (uns && (sz == 2'd2)));

    assign err_o = misalign | bad_f3;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a fixed wait-state count and an
// internal word array written through per-byte enables.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDXW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic            accept;
    logic            go_resp;
    logic            ex_we;
    logic [2:0]      ex_f3;
    logic [31:0]     ex_addr;
    logic [31:0]     ex_wdata;
    logic [IDXW-1:0] word_idx;
    logic            in_range;
    logic            ex_err;
    logic [3:0]      be;
    logic [31:0]     wdata_sh;
    logic [31:0]     rdata_ext;
    logic            align_err;

    // With zero wait states the access executes on the accept edge, so the
    // live request fields feed the datapath while in IDLE.
    assign ex_we    = (state_q == IDLE) ? req_we     : we_q;
    assign ex_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
    assign ex_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    assign ex_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;

    assign word_idx = ex_addr[IDXW+1:2];
    assign in_range = {2'b00, ex_addr[31:2]} < 32'(DEPTH_WORDS);
    assign ex_err   = align_err | ~in_range;

    dmem_lane_align u_align (
        .we_i       (ex_we),
        .funct3_i   (ex_f3),
        .addr_lo_i  (ex_addr[1:0]),
        .wdata_i    (ex_wdata),
        .raw_i      (mem_q[word_idx]),
        .be_o       (be),
        .wdata_sh_o (wdata_sh),
        .rdata_o    (rdata_ext),
        .err_o      (align_err)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = reset && (state_q == IDLE);
        rsp_valid = reset && (state_q == RESP);
        accept    = (state_q == IDLE) && req_valid;
        go_resp   = ((state_q == IDLE) && req_valid && (WAIT_STATES == 0))
                 || ((state_q == WAIT) && (cnt_q == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (go_resp) begin
                rdata_q <= (ex_err || ex_we) ? 32'd0 : rdata_ext;
                err_q   <= ex_err;
            end
        end
    end

    // Array is not reset; a store only lands if reset is inactive on its execute edge.
    always_ff @(posedge clk) begin
        if (reset && go_resp && ex_we && !ex_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: u0 runs with one wait state, u1 with three (reset-abort case).
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [2:0]  req_f3    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [31:0] rsp_rdata [2];

    int n_chk  = 0;
    int n_pass = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u0 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_f3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u1 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_f3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // Full request/response transaction; lat counts edges from accept to rsp_valid.
    task automatic txn(input int u, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        int w;
        @(negedge clk);
        req_valid[u] = 1'b1; req_we[u] = we; req_f3[u] = f3;
        req_addr[u] = a; req_wdata[u] = wd;
        w = 0;
        while (!req_ready[u] && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk);
        req_valid[u] = 1'b0;
        lat = 1;
        while (!rsp_valid[u] && lat < 50) begin @(negedge clk); lat++; end
        if (!rsp_valid[u]) begin
            n_chk++;
            $display("FAIL txn_timeout u%0d addr=%h: no rsp_valid within %0d cycles", u, a, lat);
        end
        rd = rsp_rdata[u];
        er = rsp_err[u];
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (req_ready[0] !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready[0]);
            else n_pass++;
            n_chk++;
            if (rsp_valid[0] !== 1'b0 || rsp_valid[1] !== 1'b0)
                $display("FAIL reset_rsp_valid got=%b/%b exp=0", rsp_valid[0], rsp_valid[1]);
            else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (req_ready[0] !== 1'b1) $display("FAIL post_reset_req_ready got=%b exp=1", req_ready[0]);
        else n_pass++;
        n_chk++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0)
            $display("FAIL post_reset_rsp got v=%b d=%h e=%b exp 0/0/0", rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        else n_pass++;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, F3_LW, 32'h10, 32'hDEADBEEF, rd, er, lat);
        n_chk++;
        if (lat !== 2 || rd !== 32'd0 || er !== 1'b0)
            $display("FAIL sw_rsp got lat=%0d d=%h e=%b exp lat=2 d=0 e=0", lat, rd, er);
        else n_pass++;
        txn(0, 1'b0, F3_LW, 32'h10, 32'h0, rd, er, lat);
        n_chk++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2)
            $display("FAIL lw_raw got d=%h e=%b lat=%0d exp DEADBEEF/0/2", rd, er, lat);
        else n_pass++;
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, F3_LB, 32'h11, 32'h00000080, rd, er, lat);
        txn(0, 1'b0, F3_LB, 32'h11, 32'h0, rd, er, lat);
        n_chk++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0) $display("FAIL lb got=%h exp=FFFFFF80", rd);
        else n_pass++;
        txn(0, 1'b0, F3_LBU, 32'h11, 32'h0, rd, er, lat);
        n_chk++;
        if (rd !== 32'h00000080) $display("FAIL lbu got=%h exp=00000080", rd);
        else n_pass++;
        txn(0, 1'b0, F3_LH, 32'h10, 32'h0, rd, er, lat);
        n_chk++;
        if (rd !== 32'hFFFF80EF) $display("FAIL lh got=%h exp=FFFF80EF", rd);
        else n_pass++;
        txn(0, 1'b1, F3_LH, 32'h12, 32'hAAAA1234, rd, er, lat);
        txn(0, 1'b0, F3_LHU, 32'h12, 32'h0, rd, er, lat);
        n_chk++;
        if (rd !== 32'h00001234) $display("FAIL lhu_hi got=%h exp=00001234", rd);
        else n_pass++;
        txn(0, 1'b0, F3_LW, 32'h10, 32'h0, rd, er, lat);
        n_chk++;
        if (rd !== 32'h123480EF) $display("FAIL lw_merged got=%h exp=123480EF", rd);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b0, F3_LW, 32'h12, 32'h0, rd, er, lat);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'd0) $display("FAIL lw_misalign got d=%h e=%b exp 0/1", rd, er);
        else n_pass++;
        txn(0, 1'b0, F3_LH, 32'h13, 32'h0, rd, er, lat);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'd0) $display("FAIL lh_misalign got d=%h e=%b exp 0/1", rd, er);
        else n_pass++;
        txn(0, 1'b1, F3_LW, 32'h12, 32'hFFFFFFFF, rd, er, lat);
        n_chk++;
        if (er !== 1'b1) $display("FAIL sw_misalign got e=%b exp 1", er);
        else n_pass++;
        txn(0, 1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, rd, er, lat);
        n_chk++;
        if (er !== 1'b1) $display("FAIL store_bad_f3 got e=%b exp 1", er);
        else n_pass++;
        txn(0, 1'b0, F3_LW, 32'h10, 32'h0, rd, er, lat);
        n_chk++;
        if (rd !== 32'h123480EF || er !== 1'b0) $display("FAIL array_unchanged got d=%h e=%b exp 123480EF/0", rd, er);
        else n_pass++;
        txn(0, 1'b0, F3_LW, 32'h1000, 32'h0, rd, er, lat);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'd0) $display("FAIL lw_range got d=%h e=%b exp 0/1", rd, er);
        else n_pass++;
        txn(0, 1'b0, F3_LW, 32'hFFC, 32'h0, rd, er, lat);
        n_chk++;
        if (er !== 1'b0) $display("FAIL lw_last_word got e=%b exp 0", er);
        else n_pass++;
        txn(0, 1'b0, 3'd3, 32'h10, 32'h0, rd, er, lat);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'd0) $display("FAIL load_f3_3 got d=%h e=%b exp 0/1", rd, er);
        else n_pass++;
        txn(0, 1'b0, 3'd6, 32'h10, 32'h0, rd, er, lat);
        n_chk++;
        if (er !== 1'b1) $display("FAIL load_f3_6 got e=%b exp 1", er);
        else n_pass++;
    endtask

    task automatic test_hold();
        int w;
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_f3[0] = F3_LW; req_addr[0] = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        w = 0;
        while (!rsp_valid[0] && w < 20) begin @(negedge clk); w++; end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h123480EF || req_ready[0] !== 1'b0)
                $display("FAIL hold_c%0d got v=%b d=%h rr=%b exp 1/123480EF/0",
                         i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
            else n_pass++;
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        n_chk++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1)
            $display("FAIL hold_release got v=%b rr=%b exp 0/1", rsp_valid[0], req_ready[0]);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        txn(1, 1'b1, F3_LW, 32'h20, 32'h11111111, rd, er, lat);
        n_chk++;
        if (lat !== 4 || er !== 1'b0) $display("FAIL ws3_latency got lat=%0d e=%b exp 4/0", lat, er);
        else n_pass++;
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_f3[1] = F3_LW;
        req_addr[1] = 32'h20; req_wdata[1] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1)
            $display("FAIL abort_state got v=%b rr=%b exp 0/1", rsp_valid[1], req_ready[1]);
        else n_pass++;
        txn(1, 1'b0, F3_LW, 32'h20, 32'h0, rd, er, lat);
        n_chk++;
        if (rd !== 32'h11111111 || er !== 1'b0) $display("FAIL abort_no_write got d=%h exp 11111111", rd);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_we[u] = 1'b0; req_f3[u] = 3'd0;
            req_addr[u] = 32'd0; req_wdata[u] = 32'd0; rsp_ready[u] = 1'b0;
        end
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_hold();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
